// File: rtl/paint_ram_scheduler_pkg.sv
// Shared types and constants for the paint RAM scheduler.
// Holds RAM geometry, player colours, FSM state enum and phase codes.
package turf_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 15'h4F77;

  localparam logic [DATA_W-1:0] NO_COLOR = 3'b000;
  localparam logic [DATA_W-1:0] P1_COLOR = 3'b001;
  localparam logic [DATA_W-1:0] P2_COLOR = 3'b010;
  localparam logic [DATA_W-1:0] P3_COLOR = 3'b100;
  localparam logic [DATA_W-1:0] P4_COLOR = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_PAINT,
    S_WR1,
    S_WR2,
    S_WR3,
    S_WR4,
    S_SCAN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_CLEAR = 2'd1;
  localparam logic [1:0] PH_PAINT = 2'd2;
  localparam logic [1:0] PH_SCAN  = 2'd3;

  function automatic logic [1:0] phase_of(input state_e s);
    unique case (s)
      S_IDLE:  return PH_IDLE;
      S_CLEAR: return PH_CLEAR;
      S_SCAN,
      S_FLUSH,
      S_DONE:  return PH_SCAN;
      default: return PH_PAINT;
    endcase
  endfunction

  function automatic logic in_field(input logic [ADDR_W-1:0] a);
    return a <= LAST_ADDR;
  endfunction

endpackage

// File: rtl/paint_ram_scheduler_if.sv
// RAM port and scan-out bus of the paint RAM scheduler.
// master = scheduler (drives RAM + scan), slave = RAM/tally side.
interface paint_ram_scheduler_if;
  import turf_pkg::*;

  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              scan_valid;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_color;
  logic              scan_done;

  modport master (
    output wren, address, data,
    output scan_valid, scan_addr, scan_color, scan_done,
    input  q
  );

  modport slave (
    input  wren, address, data,
    input  scan_valid, scan_addr, scan_color, scan_done,
    output q
  );
endinterface

// File: rtl/paint_ram_scheduler_addr_sweep.sv
// Sweep counter shared by CLEAR and SCAN; holds the address on the bus.
// Ports: clr_i restart at 0, en_i step, addr_o next address, last_o at LAST.
module addr_sweep #(
  parameter int W = 15,
  parameter logic [W-1:0] LAST = 15'h4F77
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] addr_o,
  output logic         last_o
);
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !last_o)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // addr_o is the value the counter takes at the next edge, so the
  // caller can register it straight onto the RAM address bus.
  assign addr_o = cnt_d;
  assign last_o = (cnt_q == LAST);
endmodule

// File: rtl/paint_ram_scheduler.sv
// Paint RAM owner: clears the RAM, paints 4 players per tick, scans out.
// Ports: clk/reset, running, move_tick, p1..p4, phase, overrun, bus.
module paint_ram_scheduler #(
  parameter int ADDR_W = turf_pkg::ADDR_W,
  parameter int DATA_W = turf_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = turf_pkg::LAST_ADDR
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              running,
  input  logic              move_tick,
  input  logic [ADDR_W-1:0] p1,
  input  logic [ADDR_W-1:0] p2,
  input  logic [ADDR_W-1:0] p3,
  input  logic [ADDR_W-1:0] p4,
  output logic [1:0]        phase,
  output logic              overrun,
  paint_ram_scheduler_if.master bus
);
  import turf_pkg::*;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] sh_q [4];
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sv_q;
  logic [ADDR_W-1:0] sa_q, sa_d;
  logic              done_q;
  logic [1:0]        phase_q;

  logic              sw_clr, sw_en, sw_last;
  logic [ADDR_W-1:0] sw_addr;
  logic              use_sweep, latch;
  logic [ADDR_W-1:0] wr_addr;
  logic              in_wr;

  addr_sweep #(.W(ADDR_W), .LAST(LAST_ADDR)) u_sweep (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .clr_i  (sw_clr),
    .en_i   (sw_en),
    .addr_o (sw_addr),
    .last_o (sw_last)
  );

  assign in_wr = (state_q == S_WR1) || (state_q == S_WR2) ||
                 (state_q == S_WR3) || (state_q == S_WR4);

  always_comb begin
    state_d   = state_q;
    sw_clr    = 1'b0;
    sw_en     = 1'b0;
    use_sweep = 1'b0;
    wr_addr   = address_q;
    wren_d    = 1'b0;
    data_d    = NO_COLOR;
    latch     = 1'b0;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    // One-deep tick buffer while a paint burst is in flight.
    if (in_wr && move_tick) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: if (running) begin
        state_d   = S_CLEAR;
        sw_clr    = 1'b1;
        use_sweep = 1'b1;
        wren_d    = 1'b1;
      end
      S_CLEAR: begin
        if (!running)
          state_d = S_IDLE;
        else if (sw_last)
          state_d = S_PAINT;
        else begin
          sw_en     = 1'b1;
          use_sweep = 1'b1;
          wren_d    = 1'b1;
        end
      end
      S_PAINT: begin
        if (!running) begin
          state_d   = S_SCAN;
          sw_clr    = 1'b1;
          use_sweep = 1'b1;
        end else if (move_tick) begin
          state_d = S_WR1;
          latch   = 1'b1;
          wr_addr = p1;
          wren_d  = in_field(p1);
          data_d  = P1_COLOR;
        end
      end
      S_WR1: begin
        state_d = S_WR2;
        wr_addr = sh_q[1];
        wren_d  = in_field(sh_q[1]);
        data_d  = P2_COLOR;
      end
      S_WR2: begin
        state_d = S_WR3;
        wr_addr = sh_q[2];
        wren_d  = in_field(sh_q[2]);
        data_d  = P3_COLOR;
      end
      S_WR3: begin
        state_d = S_WR4;
        wr_addr = sh_q[3];
        wren_d  = in_field(sh_q[3]);
        data_d  = P4_COLOR;
      end
      S_WR4: begin
        if (!running) begin
          state_d   = S_SCAN;
          pend_d    = 1'b0;
          sw_clr    = 1'b1;
          use_sweep = 1'b1;
        end else if (pend_q || move_tick) begin
          state_d = S_WR1;
          pend_d  = 1'b0;
          latch   = 1'b1;
          wr_addr = p1;
          wren_d  = in_field(p1);
          data_d  = P1_COLOR;
        end else
          state_d = S_PAINT;
      end
      S_SCAN: begin
        if (sw_last)
          state_d = S_FLUSH;
        else begin
          sw_en     = 1'b1;
          use_sweep = 1'b1;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: if (running) begin
        state_d   = S_CLEAR;
        ovr_d     = 1'b0;
        sw_clr    = 1'b1;
        use_sweep = 1'b1;
        wren_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Kept outside the FSM block so the sweep feedback is not a loop.
  assign address_d = use_sweep ? sw_addr : wr_addr;
  assign sa_d = (state_q == S_SCAN) ? address_q : sa_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wren_q    <= 1'b0;
      address_q <= '0;
      data_q    <= NO_COLOR;
      sv_q      <= 1'b0;
      sa_q      <= '0;
      done_q    <= 1'b0;
      phase_q   <= PH_IDLE;
      for (int i = 0; i < 4; i++) sh_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      wren_q    <= wren_d;
      address_q <= address_d;
      data_q    <= data_d;
      sv_q      <= (state_q == S_SCAN);
      sa_q      <= sa_d;
      done_q    <= (state_d == S_DONE);
      phase_q   <= phase_of(state_d);
      if (latch) begin
        sh_q[0] <= p1;
        sh_q[1] <= p2;
        sh_q[2] <= p3;
        sh_q[3] <= p4;
      end
    end
  end

  assign bus.wren       = wren_q;
  assign bus.address    = address_q;
  assign bus.data       = data_q;
  assign bus.scan_valid = sv_q;
  assign bus.scan_addr  = sa_q;
  // RAM read data lands one cycle after the address, aligned with sv_q.
  assign bus.scan_color = sv_q ? bus.q : NO_COLOR;
  assign bus.scan_done  = done_q;
  assign phase          = phase_q;
  assign overrun        = ovr_q;
endmodule

// File: tb/tb_paint_ram_scheduler.sv
// Directed bench for paint_ram_scheduler with a behavioural RAM model.
// Checks clear, paint bursts, tick buffering, scan-out and resets.
module tb_paint_ram_scheduler;
  logic clk, rst, running, move_tick;
  logic [14:0] p1, p2, p3, p4;
  logic [1:0] phase;
  logic overrun;
  int n_chk, n_pass, n_fail;
  int bad, idx, gap, clash, n;
  logic last_valid;

  logic [2:0] mem [32768];

  paint_ram_scheduler_if bus();

  paint_ram_scheduler dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .running   (running),
    .move_tick (move_tick),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .phase     (phase),
    .overrun   (overrun),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-old-data.
  always @(posedge clk) begin
    bus.q <= mem[bus.address];
    if (bus.wren) mem[bus.address] = bus.data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic [14:0] a,
                                     input logic [2:0] d);
    return {13'd0, 1'b1, a, d};
  endfunction

  function automatic logic [31:0] bus_now();
    return {13'd0, bus.wren, bus.address, bus.data};
  endfunction

  function automatic logic [2:0] expc(input int a);
    case (a)
      'h4F77, 'h0010, 'h0020, 'h0030: return 3'b001;
      'h0001, 'h0011, 'h0021, 'h0031: return 3'b010;
      'h4F01, 'h0100, 'h0012, 'h0022, 'h0032: return 3'b100;
      'h0077, 'h0200, 'h0013, 'h0023, 'h0033: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; running = 1'b0; move_tick = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;
    for (int a = 0; a < 32768; a++) mem[a] = 3'((a % 7) + 1);
    step(); step();
    chk("rst_wren", bus.wren, 0);
    chk("rst_addr", bus.address, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_sv", bus.scan_valid, 0);
    chk("rst_sa", bus.scan_addr, 0);
    chk("rst_sc", bus.scan_color, 0);
    chk("rst_done", bus.scan_done, 0);
    chk("rst_phase", phase, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    step();
    chk("idle_wren", bus.wren, 0);

    running = 1'b1;
    step();
    chk("clr_phase", phase, 1);
    bad = 0;
    for (int i = 0; i < 20344; i++) begin
      if (bus_now() !== wr(15'(i), 3'b000)) bad++;
      step();
    end
    chk("clr_writes", bad, 0);
    chk("clr_to_paint", phase, 2);
    chk("paint_wren", bus.wren, 0);

    p1 = 15'h4F77; p2 = 15'h0001; p3 = 15'h4F01; p4 = 15'h0077;
    move_tick = 1'b1; step(); move_tick = 1'b0;
    chk("a_wr1", bus_now(), wr(15'h4F77, 3'b001)); step();
    chk("a_wr2", bus_now(), wr(15'h0001, 3'b010)); step();
    chk("a_wr3", bus_now(), wr(15'h4F01, 3'b100)); step();
    chk("a_wr4", bus_now(), wr(15'h0077, 3'b110)); step();
    chk("a_back_wren", bus.wren, 0);
    chk("a_back_phase", phase, 2);

    p1 = 15'h7FFF; p2 = 15'h0100; p3 = 15'h0100; p4 = 15'h0200;
    move_tick = 1'b1; step(); move_tick = 1'b0;
    chk("b_wr1_supp", bus.wren, 0); step();
    chk("b_wr2", bus_now(), wr(15'h0100, 3'b010)); step();
    chk("b_wr3", bus_now(), wr(15'h0100, 3'b100)); step();
    chk("b_wr4", bus_now(), wr(15'h0200, 3'b110)); step();
    chk("b_back", bus.wren, 0);

    p1 = 15'h0010; p2 = 15'h0011; p3 = 15'h0012; p4 = 15'h0013;
    move_tick = 1'b1; step(); move_tick = 1'b0;
    chk("c_wr1", bus_now(), wr(15'h0010, 3'b001)); step();
    chk("c_wr2", bus_now(), wr(15'h0011, 3'b010));
    p1 = 15'h0020; p2 = 15'h0021; p3 = 15'h0022; p4 = 15'h0023;
    move_tick = 1'b1; step();
    chk("c_wr3", bus_now(), wr(15'h0012, 3'b100));
    chk("c_ovr_before", overrun, 0);
    step(); move_tick = 1'b0;
    chk("c_wr4", bus_now(), wr(15'h0013, 3'b110));
    chk("c_ovr", overrun, 1); step();
    chk("c2_wr1", bus_now(), wr(15'h0020, 3'b001)); step();
    chk("c2_wr2", bus_now(), wr(15'h0021, 3'b010)); step();
    chk("c2_wr3", bus_now(), wr(15'h0022, 3'b100)); step();
    chk("c2_wr4", bus_now(), wr(15'h0023, 3'b110)); step();
    chk("c_back_wren", bus.wren, 0);
    chk("c_back_phase", phase, 2);
    chk("c_ovr_sticky", overrun, 1);

    p1 = 15'h0030; p2 = 15'h0031; p3 = 15'h0032; p4 = 15'h0033;
    move_tick = 1'b1; step(); move_tick = 1'b0;
    chk("d_wr1", bus_now(), wr(15'h0030, 3'b001)); step();
    chk("d_wr2", bus_now(), wr(15'h0031, 3'b010));
    running = 1'b0; step();
    chk("d_wr3", bus_now(), wr(15'h0032, 3'b100)); step();
    chk("d_wr4", bus_now(), wr(15'h0033, 3'b110)); step();
    chk("scan_phase", phase, 3);
    chk("scan_first", {bus.wren, bus.address}, 0);
    chk("scan_sv0", bus.scan_valid, 0);

    idx = 0; bad = 0; gap = 0; clash = 0; last_valid = 1'b0;
    for (n = 0; n < 20400; n++) begin
      step();
      if (bus.scan_valid && bus.wren) clash++;
      if (bus.scan_done) break;
      if (bus.scan_valid) begin
        if (bus.scan_addr !== 15'(idx) || bus.scan_color !== expc(idx))
          bad++;
        idx++;
      end else if (idx > 0) gap++;
      last_valid = bus.scan_valid;
    end
    chk("scan_timeout", n < 20400, 1);
    chk("scan_count", idx, 20344);
    chk("scan_data", bad, 0);
    chk("scan_gaps", gap, 0);
    chk("scan_clash", clash, 0);
    chk("done_edge", {last_valid, bus.scan_valid}, 2'b10);
    chk("done_level", bus.scan_done, 1);
    chk("done_ovr", overrun, 1);

    running = 1'b1; step();
    chk("re_clr", bus_now(), wr(15'h0000, 3'b000));
    chk("re_ovr", overrun, 0);
    chk("re_done", bus.scan_done, 0);
    repeat (20344) step();
    chk("re_paint", phase, 2);
    running = 1'b0; step();
    chk("re_scan", phase, 3);
    for (n = 0; n < 5000 && bus.address !== 15'h1234; n++) step();
    chk("reach_1234", bus.address, 15'h1234);
    rst = 1'b1; step();
    chk("mid_rst_wren", bus.wren, 0);
    chk("mid_rst_sv", bus.scan_valid, 0);
    chk("mid_rst_phase", phase, 0);
    rst = 1'b0; running = 1'b1; step();
    chk("rst_restart", bus_now(), wr(15'h0000, 3'b000));
    chk("rst_restart_ph", phase, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
